uart_channel_rx: RTL and testbench

Parametrised UART frame receiver with a built-in channel loader. It deserialises start/data/parity/stop frames from the `Rx` pin and checks parity and framing. Each good word is written round-robin into one of `NUM_CH` channel registers. It is the next-generation front end of the colour-processor top and feeds channel values to the colour processor and the 7-segment debug path.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_bit_timer.sv | 31 +++
 rtl/uart_channel_rx.sv | 160 ++++++++++++++++
 tb/tb_uart_channel_rx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, parity-mode constants and width helper for uart_channel_rx.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int ptr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period down-counter with half-bit preload, ticking once per sample point.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load_half,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && cnt_q == '0;

    // Preload half a bit on start detect so later ticks land mid-bit; reload a full bit after each tick.
    always_comb begin
        cnt_d = load_half ? CW'(CLKS_PER_BIT / 2 - 1)
              : tick      ? CW'(CLKS_PER_BIT - 1)
              : en        ? cnt_q - 1'b1
              :             cnt_q;
    end

    // Counter register.
    always_ff @(posedge clk) begin
        cnt_q <= rst ? '0 : cnt_d;
    end

endmodule

// File: rtl/uart_channel_rx.sv
// uart_channel_rx: UART frame receiver that loads good words round-robin into NUM_CH channel registers.
// Optional macro UART_RX_SYNC_EN: pass Rx through a two-flop synchroniser (adds two cycles of latency).
module uart_channel_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 32,
    parameter int DATA_W       = 8,
    parameter int PARITY_MODE  = PAR_EVEN,
    parameter int NUM_CH       = 3,
    localparam int PW          = ptr_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Rx,
    input  logic                     clr_ptr,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_valid,
    output logic                     parity_err,
    output logic                     frame_err,
    output logic [PW-1:0]            ch_ptr,
    output logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     busy
);

    localparam int BW = $clog2(DATA_W + 1);

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;
    logic [1:0] sync_d;
    assign sync_d = {sync_q[0], Rx};
    assign rx_s   = sync_q[1];
    // Two-flop synchroniser, reset to the idle-high line level.
    always_ff @(posedge clk) begin
        sync_q <= rst ? 2'b11 : sync_d;
    end
`else
    assign rx_s = Rx;
`endif

    rx_state_e            state_q, state_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]    shift_q, shift_d;
    logic                 par_bad_q, par_bad_d;
    logic                 done_q, done_d;
    logic                 stop_q, stop_d;
    logic [DATA_W-1:0]    data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic [PW-1:0]        ch_ptr_q, ch_ptr_d;
    logic [NUM_CH*DATA_W-1:0] ch_data_q, ch_data_d;
    logic                 busy_q, busy_d;
    logic                 tick, load_half, timer_en, good;

    assign timer_en = state_q != S_IDLE;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .en        (timer_en),
        .load_half (load_half),
        .tick      (tick)
    );

    // Frame FSM: start check, LSB-first data shift, parity check, stop sample.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        stop_d    = stop_q;
        done_d    = 1'b0;
        load_half = 1'b0;
        case (state_q)
            S_IDLE: if (!rx_s) begin
                state_d   = S_START;
                load_half = 1'b1;
                bit_cnt_d = '0;
                par_bad_d = 1'b0;
            end
            S_START: if (tick) state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA: if (tick) begin
                shift_d   = {rx_s, shift_q[DATA_W-1:1]};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BW'(DATA_W - 1))
                    state_d = (PARITY_MODE == PAR_NONE) ? S_STOP : S_PARITY;
            end
            S_PARITY: if (tick) begin
                par_bad_d = (^shift_q ^ rx_s) != (PARITY_MODE == PAR_ODD);
                state_d   = S_STOP;
            end
            S_STOP: if (tick) begin
                stop_d  = rx_s;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Commit one cycle after the stop sample; framing errors win over parity errors.
    always_comb begin
        good         = done_q && stop_q && !par_bad_q;
        data_valid_d = good;
        parity_err_d = done_q && stop_q && par_bad_q;
        frame_err_d  = done_q && !stop_q;
        data_out_d   = good ? shift_q : data_out_q;
        ch_ptr_d     = clr_ptr ? '0
                     : good    ? ((ch_ptr_q == PW'(NUM_CH - 1)) ? '0 : ch_ptr_q + 1'b1)
                     :           ch_ptr_q;
        busy_d       = state_q != S_IDLE;
        ch_data_d    = ch_data_q;
        for (int k = 0; k < NUM_CH; k++)
            if (good && ch_ptr_q == PW'(k)) ch_data_d[k*DATA_W +: DATA_W] = shift_q;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            stop_q       <= 1'b1;
            done_q       <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            ch_ptr_q     <= '0;
            ch_data_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            stop_q       <= stop_d;
            done_q       <= done_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            ch_ptr_q     <= ch_ptr_d;
            ch_data_q    <= ch_data_d;
            busy_q       <= busy_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign ch_ptr     = ch_ptr_q;
    assign ch_data    = ch_data_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_channel_rx.sv
// tb_uart_channel_rx: table-driven and randomized frame checks against a word-level channel model.
module tb_uart_channel_rx;
    import uart_pkg::*;

    localparam int CPB   = 32;
    localparam int DW    = 8;
    localparam int PM    = PAR_EVEN;
    localparam int NCH   = 3;
    localparam int PW    = ptr_w(NCH);
    localparam int P     = (PM != PAR_NONE) ? 1 : 0;
    localparam int SS    = CPB / 2 + (DW + 1 + P) * CPB;
    localparam int FRAME = (DW + 2 + P) * CPB;

    logic clk = 1'b0, rst = 1'b1, rx = 1'b1, clr_ptr = 1'b0;
    logic [DW-1:0]     data_out;
    logic              data_valid, parity_err, frame_err, busy;
    logic [PW-1:0]     ch_ptr;
    logic [NCH*DW-1:0] ch_data;

    int checks = 0, failures = 0;
    int cyc = 0, e_cyc = 0, pulse_cyc = 0, n_v = 0, n_p = 0, n_f = 0;

    logic [DW-1:0] m_ch [NCH];
    int            m_ptr = 0;
    logic [DW-1:0] m_dout = '0;

    typedef struct {
        logic [DW-1:0] d;
        logic          p;
        logic          s;
        logic          clr;
        int            v;
        int            pe;
        int            fe;
        int            ptr;
    } vec_t;
    vec_t vecs [9];

    uart_channel_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (DW),
        .PARITY_MODE  (PM),
        .NUM_CH       (NCH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Rx         (rx),
        .clr_ptr    (clr_ptr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .ch_ptr     (ch_ptr),
        .ch_data    (ch_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        n_v <= n_v + int'(data_valid);
        n_p <= n_p + int'(parity_err);
        n_f <= n_f + int'(frame_err);
        if (data_valid || parity_err || frame_err) pulse_cyc <= cyc;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic bit_at(input int b, input logic [DW-1:0] d, input logic p, input logic s);
        if (b == 0) return 1'b0;
        if (b <= DW) return d[b-1];
        if (P == 1 && b == DW + 1) return p;
        return s;
    endfunction

    function automatic logic good_par(input logic [DW-1:0] d);
        return logic'(($countones(d) % 2) != ((PM == PAR_ODD) ? 1 : 0));
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_dout"}, data_out, m_dout);
        chk({tag, "_ptr"}, ch_ptr, m_ptr);
        for (int k = 0; k < NCH; k++) chk({tag, "_ch"}, ch_data[k*DW +: DW], m_ch[k]);
    endtask

    task automatic run_frame(input logic [DW-1:0] d, input logic p, input logic s, input logic clr,
                             output int dv, output int dp, output int df);
        int  v0, p0, f0;
        bit  par_ok, ok;
        v0 = n_v; p0 = n_p; f0 = n_f;
        for (int t = 0; t < FRAME; t++) begin
            @(negedge clk);
            if (t == 0) e_cyc = cyc + 1;
            rx      = bit_at(t / CPB, d, p, s);
            clr_ptr = clr && (t == SS + 1);
        end
        clr_ptr = 1'b0;
        rx      = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        dv = n_v - v0; dp = n_p - p0; df = n_f - f0;
        par_ok = (P == 0) || ((($countones(d) + int'(p)) % 2) == ((PM == PAR_ODD) ? 1 : 0));
        ok = s && par_ok;
        if (ok) begin
            m_ch[m_ptr] = d;
            m_dout      = d;
            m_ptr       = (m_ptr + 1) % NCH;
        end
        if (clr) m_ptr = 0;
        chk("valid_cnt", dv, int'(ok));
        chk("perr_cnt", dp, int'(s && !par_ok));
        chk("ferr_cnt", df, int'(!s));
        chk("pulse_time", pulse_cyc, e_cyc + SS + 1);
        chk("busy_idle", busy, 0);
        check_state("frame");
    endtask

    initial begin
        int dv, dp, df;
        logic [DW-1:0] d;
        logic p, s, c;
        for (int k = 0; k < NCH; k++) m_ch[k] = '0;
        vecs[0] = '{8'h10, 1'b1, 1'b1, 1'b0, 1, 0, 0, 1};
        vecs[1] = '{8'h20, 1'b1, 1'b1, 1'b0, 1, 0, 0, 2};
        vecs[2] = '{8'h30, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0};
        vecs[3] = '{8'h40, 1'b1, 1'b1, 1'b0, 1, 0, 0, 1};
        vecs[4] = '{8'h21, 1'b0, 1'b1, 1'b0, 1, 0, 0, 2};
        vecs[5] = '{8'h21, 1'b1, 1'b1, 1'b0, 0, 1, 0, 2};
        vecs[6] = '{8'h5A, 1'b0, 1'b0, 1'b0, 0, 0, 1, 2};
        vecs[7] = '{8'h5A, 1'b1, 1'b0, 1'b0, 0, 0, 1, 2};
        vecs[8] = '{8'h33, 1'b0, 1'b1, 1'b1, 1, 0, 0, 0};

        repeat (3) @(negedge clk);
        chk("rst_dout", data_out, 0);
        chk("rst_ptr", ch_ptr, 0);
        chk("rst_ch", ch_data, 0);
        chk("rst_pulses", {data_valid, parity_err, frame_err}, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_frame(vecs[i].d, vecs[i].p, vecs[i].s, vecs[i].clr, dv, dp, df);
            chk("tbl_valid", dv, vecs[i].v);
            chk("tbl_perr", dp, vecs[i].pe);
            chk("tbl_ferr", df, vecs[i].fe);
            chk("tbl_ptr", ch_ptr, vecs[i].ptr);
            if (i == 3) chk("rr_channels", ch_data, {8'h30, 8'h20, 8'h40});
        end
        chk("clr_write_ch2", ch_data[2*DW +: DW], 8'h33);

        // Glitch: low for 5 cycles, FSM gives up at E+16 and busy drops one cycle later.
        dv = n_v + n_p + n_f;
        for (int t = 0; t < 24; t++) begin
            @(negedge clk);
            rx = (t < 5) ? 1'b0 : 1'b1;
            if (t == 1)  chk("glitch_busy_e", busy, 0);
            if (t == 2)  chk("glitch_busy_e1", busy, 1);
            if (t == 17) chk("glitch_busy_e16", busy, 1);
            if (t == 18) chk("glitch_busy_e17", busy, 0);
        end
        repeat (2 * CPB) @(negedge clk);
        chk("glitch_pulses", n_v + n_p + n_f, dv);
        check_state("glitch");
        run_frame(8'h21, 1'b0, 1'b1, 1'b0, dv, dp, df);

        // Reset mid-frame, then a clean 0x55 lands in channel 0.
        for (int t = 0; t < 4 * CPB; t++) begin
            @(negedge clk);
            rx = bit_at(t / CPB, 8'h55, 1'b0, 1'b1);
        end
        chk("busy_pre_rst", busy, 1);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_dout", data_out, 0);
        chk("mid_rst_ptr", ch_ptr, 0);
        chk("mid_rst_ch", ch_data, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0;
        for (int k = 0; k < NCH; k++) m_ch[k] = '0;
        m_ptr = 0; m_dout = '0;
        repeat (CPB) @(negedge clk);
        run_frame(8'h55, 1'b0, 1'b1, 1'b0, dv, dp, df);
        chk("post_rst_ch0", ch_data[DW-1:0], 8'h55);
        chk("post_rst_ptr", ch_ptr, 1);

        for (int i = 0; i < 25; i++) begin
            d = DW'($urandom);
            p = ($urandom_range(3) == 0) ? ~good_par(d) : good_par(d);
            s = ($urandom_range(5) != 0);
            c = ($urandom_range(4) == 0);
            run_frame(d, p, s, c, dv, dp, df);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
